// File: rtl/aes_stream_loader_if.sv
// Byte-stream and aes_core bus bundle for aes_stream_loader.
// The slave modport is the loader's view; master is the byte source, byte sink and core side.
interface aes_stream_loader_if;
  logic         in_valid_i;
  logic [7:0]   in_data_i;
  logic         in_ready_o;
  logic         core_load_o;
  logic [255:0] core_key_o;
  logic [127:0] core_data_o;
  logic [1:0]   core_size_o;
  logic         core_dec_o;
  logic         core_busy_i;
  logic [127:0] core_result_i;
  logic         out_valid_o;
  logic [7:0]   out_data_o;
  logic         out_ready_i;

  modport slave (
    input  in_valid_i, in_data_i, core_busy_i, core_result_i, out_ready_i,
    output in_ready_o, core_load_o, core_key_o, core_data_o, core_size_o,
           core_dec_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, core_busy_i, core_result_i, out_ready_i,
    input  in_ready_o, core_load_o, core_key_o, core_data_o, core_size_o,
           core_dec_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/aes_stream_loader.sv
// Packs key/data bytes for aes_core, pulses load, waits out the busy handshake
// and streams the 16-byte result back out MSB first.
module aes_stream_loader #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_i,
  input  logic [1:0]           size_i,
  input  logic                 dec_i,
  input  logic                 key_keep_i,
  output logic                 busy_o,
  output logic                 err_o,
  aes_stream_loader_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, KEY, DATA, LOAD, WAIT, OUT} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t       state_q;
  logic [4:0]   cnt_q;
  logic [1:0]   size_q;
  logic         dec_q;
  logic [255:0] key_q;
  logic [127:0] data_q;
  logic [127:0] shift_q;
  logic [15:0]  to_q;
  logic         seen_busy_q;
  logic         load_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         busy_q;
  logic         err_q;

  logic         in_fire;
  logic         out_fire;
  logic [4:0]   key_last;

  assign in_fire  = bus.in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready_i;

  always_comb begin
    key_last = 5'd31;
    case (size_q)
      2'd0:    key_last = 5'd15;
      2'd1:    key_last = 5'd23;
      default: key_last = 5'd31;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= '0;
      dec_q       <= 1'b0;
      key_q       <= '0;
      data_q      <= '0;
      shift_q     <= '0;
      to_q        <= '0;
      seen_busy_q <= 1'b0;
      load_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            size_q     <= size_i;
            dec_q      <= dec_i;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            if (key_keep_i) begin
              state_q <= DATA;
            end else begin
              // Fresh key: clear so bytes beyond the key length read as zero.
              key_q   <= '0;
              state_q <= KEY;
            end
          end
        end

        KEY: begin
          if (in_fire) begin
            key_q[{5'd31 - cnt_q, 3'b000} +: 8] <= bus.in_data_i;
            if (cnt_q == key_last) begin
              cnt_q   <= '0;
              state_q <= DATA;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end

        DATA: begin
          if (in_fire) begin
            data_q[{4'd15 - cnt_q[3:0], 3'b000} +: 8] <= bus.in_data_i;
            if (cnt_q == 5'd15) begin
              cnt_q      <= '0;
              in_ready_q <= 1'b0;
              load_q     <= 1'b1;
              state_q    <= LOAD;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end

        LOAD: begin
          load_q      <= 1'b0;
          to_q        <= '0;
          seen_busy_q <= 1'b0;
          state_q     <= WAIT;
        end

        WAIT: begin
          to_q <= to_q + 16'd1;
          // A capture in the same cycle the budget runs out still wins.
          if (seen_busy_q && !bus.core_busy_i) begin
            shift_q     <= bus.core_result_i;
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end else if (to_q == TO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (bus.core_busy_i) begin
            seen_busy_q <= 1'b1;
          end
        end

        OUT: begin
          if (out_fire) begin
            shift_q <= {shift_q[119:0], 8'h00};
            if (cnt_q == 5'd15) begin
              cnt_q       <= '0;
              out_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.core_load_o = load_q;
  assign bus.core_key_o  = key_q;
  assign bus.core_data_o = data_q;
  assign bus.core_size_o = size_q;
  assign bus.core_dec_o  = dec_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = shift_q[127:120];
  assign busy_o          = busy_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Scoreboard bench for aes_stream_loader: expected loads and result bytes are queued
// at issue time and popped by an independent monitor, with a small aes_core stand-in.
module tb_aes_stream_loader;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_i = 1'b0;
  logic [1:0] size_i = 2'd0;
  logic       dec_i = 1'b0;
  logic       key_keep_i = 1'b0;
  logic       busy_o;
  logic       err_o;

  aes_stream_loader_if bus ();

  aes_stream_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (start_i),
    .size_i     (size_i),
    .dec_i      (dec_i),
    .key_keep_i (key_keep_i),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miss_cnt = 0;

  logic [7:0]   out_exp [$];
  logic [255:0] key_exp [$];
  logic [127:0] data_exp [$];
  logic [2:0]   ctl_exp [$];

  int           load_cnt = 0;
  int           acc_cnt = 0;
  bit           busy_chk = 1'b0;
  bit           stall_on = 1'b0;
  int           stall_left = 0;
  bit           core_dead = 1'b0;
  int           busy_len = 1;
  logic [127:0] model_res = '0;

  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KFIPS = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PFIPS = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CFIPS = 128'h3925841d02dc09fbdc118597196a0b32;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vec_cnt++;
    miss_cnt++;
    $display("FAIL %s", name);
  endtask

  // Monitor: loads and output bytes, compared against the queued expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (busy_chk) begin
        busy_chk = 1'b0;
        chk("busy_after_last", {255'd0, busy_o}, 256'd0);
        chk("valid_after_last", {255'd0, bus.out_valid_o}, 256'd0);
      end
      if (reset_n) begin
        if (bus.core_load_o) begin
          load_cnt++;
          if (key_exp.size() == 0) begin
            flag("unexpected_load");
          end else begin
            chk("load_key", bus.core_key_o, key_exp.pop_front());
            chk("load_data", {128'd0, bus.core_data_o}, {128'd0, data_exp.pop_front()});
            chk("load_size_dec", {253'd0, bus.core_size_o, bus.core_dec_o}, {253'd0, ctl_exp.pop_front()});
          end
        end
        if (bus.out_valid_o) begin
          if (out_exp.size() == 0) begin
            flag("unexpected_out_byte");
          end else if (bus.out_ready_i) begin
            chk("out_byte", {248'd0, bus.out_data_o}, {248'd0, out_exp.pop_front()});
            if (acc_cnt == 15) begin
              acc_cnt  = 0;
              busy_chk = 1'b1;
              chk("busy_at_last", {255'd0, busy_o}, 256'd1);
            end else begin
              acc_cnt++;
            end
          end else begin
            chk("stall_hold", {248'd0, bus.out_data_o}, {248'd0, out_exp[0]});
          end
        end
      end
    end
  end

  // Downstream sink: ready high except for a programmed stall on byte 3.
  initial begin
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_on && acc_cnt == 3 && stall_left > 0) begin
        bus.out_ready_i = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready_i = 1'b1;
      end
    end
  end

  // aes_core stand-in: busy for busy_len cycles after load, then presents model_res.
  initial begin
    bus.core_busy_i   = 1'b0;
    bus.core_result_i = '0;
    forever begin
      @(negedge clk);
      if (bus.core_load_o && reset_n && !core_dead) begin
        @(posedge clk);
        #1;
        bus.core_busy_i   = 1'b1;
        bus.core_result_i = ~model_res;
        repeat (busy_len) @(posedge clk);
        #1;
        bus.core_busy_i   = 1'b0;
        bus.core_result_i = model_res;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [1:0] s, input logic d, input logic k);
    start_i    = 1'b1;
    size_i     = s;
    dec_i      = d;
    key_keep_i = k;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = b;
    @(negedge clk);
    while (!bus.in_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) flag("in_ready_timeout");
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_vec(input logic [255:0] v, input int nbytes, input bit gaps);
    for (int i = 0; i < nbytes; i++)
      send_byte(v[255 - 8*i -: 8], gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic expect_op(input logic [255:0] k, input logic [127:0] d,
                           input logic [1:0] s, input logic dc, input logic [127:0] res);
    key_exp.push_back(k);
    data_exp.push_back(d);
    ctl_exp.push_back({s, dc});
    for (int i = 0; i < 16; i++) out_exp.push_back(res[127 - 8*i -: 8]);
    model_res = res;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy_o || out_exp.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) flag(name);
    chk("queue_drained", 256'(out_exp.size()), 256'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero();
    chk("rst_in_ready", {255'd0, bus.in_ready_o}, 256'd0);
    chk("rst_load", {255'd0, bus.core_load_o}, 256'd0);
    chk("rst_key", bus.core_key_o, 256'd0);
    chk("rst_data", {128'd0, bus.core_data_o}, 256'd0);
    chk("rst_size_dec", {253'd0, bus.core_size_o, bus.core_dec_o}, 256'd0);
    chk("rst_out", {247'd0, bus.out_valid_o, bus.out_data_o}, 256'd0);
    chk("rst_busy_err", {254'd0, busy_o, err_o}, 256'd0);
  endtask

  int l0;
  int t;

  initial begin
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // AES-128 encrypt.
    l0 = load_cnt;
    busy_len = 1;
    expect_op(K128, PT0, 2'd0, 1'b0, CT128);
    pulse_start(2'd0, 1'b0, 1'b0);
    send_vec(K128, 16, 1'b0);
    send_vec({PT0, 128'd0}, 16, 1'b0);
    wait_idle("t1_done_timeout");
    chk("t1_loads", 256'(load_cnt - l0), 256'd1);

    // AES-256 full key, then a key_keep decrypt reusing it.
    busy_len = 3;
    expect_op(K256, PT0, 2'd2, 1'b0, CT256);
    pulse_start(2'd2, 1'b0, 1'b0);
    send_vec(K256, 32, 1'b0);
    send_vec({PT0, 128'd0}, 16, 1'b0);
    wait_idle("t2a_done_timeout");
    l0 = load_cnt;
    expect_op(K256, CT256, 2'd2, 1'b1, PT0);
    pulse_start(2'd2, 1'b1, 1'b1);
    send_vec({CT256, 128'd0}, 16, 1'b0);
    @(negedge clk);
    chk("t2_ready_drop", {255'd0, bus.in_ready_o}, 256'd0);
    wait_idle("t2b_done_timeout");
    chk("t2_loads", 256'(load_cnt - l0), 256'd1);
    chk("t2_key_stable", bus.core_key_o, K256);

    // Input gaps and a 5-cycle output stall on byte 3.
    stall_on = 1'b1;
    stall_left = 5;
    expect_op(KFIPS, PFIPS, 2'd0, 1'b0, CFIPS);
    pulse_start(2'd0, 1'b0, 1'b0);
    send_vec(KFIPS, 16, 1'b1);
    send_vec({PFIPS, 128'd0}, 16, 1'b1);
    wait_idle("t3_done_timeout");
    chk("t3_stall_used", 256'(stall_left), 256'd0);
    stall_on = 1'b0;

    // Timeout: the core never raises busy.
    core_dead = 1'b1;
    key_exp.push_back(KFIPS);
    data_exp.push_back(PT0);
    ctl_exp.push_back(3'b000);
    pulse_start(2'd0, 1'b0, 1'b1);
    send_vec({PT0, 128'd0}, 16, 1'b0);
    @(negedge clk);
    chk("t4_load_seen", {255'd0, bus.core_load_o}, 256'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.out_valid_o) flag("t4_out_valid_in_wait");
    end
    chk("t4_err_before", {254'd0, err_o, busy_o}, 256'd1);
    @(negedge clk);
    chk("t4_err_busy", {254'd0, err_o, busy_o}, 256'd2);
    chk("t4_no_out", {255'd0, bus.out_valid_o}, 256'd0);
    core_dead = 1'b0;
    @(posedge clk);
    #1;
    pulse_start(2'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_err_cleared", {254'd0, err_o, busy_o}, 256'd1);

    // Reset after 7 data bytes of that operation.
    @(posedge clk);
    #1;
    l0 = load_cnt;
    send_vec({PT0, 128'd0}, 7, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_all_zero();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_load_after_reset", 256'(load_cnt - l0), 256'd0);

    // AES-192 after reset: low 64 key bits must read zero.
    expect_op(K192, PT0, 2'd1, 1'b0, CT192);
    pulse_start(2'd1, 1'b0, 1'b0);
    send_vec(K192, 24, 1'b0);
    send_vec({PT0, 128'd0}, 16, 1'b0);
    wait_idle("t5_done_timeout");

    // start_i pulses during KEY and during OUT are ignored.
    l0 = load_cnt;
    expect_op(K128, CT128, 2'd0, 1'b1, PT0);
    pulse_start(2'd0, 1'b1, 1'b0);
    send_vec(K128, 5, 1'b0);
    pulse_start(2'd2, 1'b0, 1'b1);
    send_vec(K128 << 40, 11, 1'b0);
    send_vec({CT128, 128'd0}, 16, 1'b0);
    t = 0;
    @(negedge clk);
    while (!(bus.out_valid_o && acc_cnt == 4) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) flag("t6_out_timeout");
    @(posedge clk);
    #1;
    pulse_start(2'd2, 1'b0, 1'b0);
    wait_idle("t6_done_timeout");
    repeat (10) @(posedge clk);
    #1;
    chk("t6_loads", 256'(load_cnt - l0), 256'd1);
    chk("t6_size_dec_held", {253'd0, bus.core_size_o, bus.core_dec_o}, 256'd1);
    chk("t6_key_held", bus.core_key_o, K128);
    chk("t6_idle_busy", {255'd0, busy_o}, 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
